// File: rtl/deserializador_fifo.sv
// deserializador_fifo: serial-to-parallel word assembler feeding a small output FIFO,
// with an edge-detected acknowledge that pops one word per ack rising edge.
module deserializador_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1
) (
    input  logic                                clock_100KHz,
    input  logic                                reset,
    input  logic                                data_in,
    input  logic                                write_in,
    input  logic                                ack_in,
    output logic                                status_out,
    output logic                                data_ready,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                overrun_out
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, BLOCKED} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] shift_reg, shift_nx;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [BW-1:0]         bits_count;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  ack_q, accept, last, push, pop;

    assign status_out = fifo_count != CW'(FIFO_DEPTH);
    assign data_ready = fifo_count != '0;
    assign accept     = write_in & status_out;
    assign last       = bits_count == BW'(DATA_WIDTH - 1);
    assign push       = accept & last;
    assign pop        = ack_in & ~ack_q & data_ready;
    assign shift_nx   = MSB_FIRST ? {shift_reg[DATA_WIDTH-2:0], data_in}
                                  : {data_in, shift_reg[DATA_WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        if (push)
            state_nx = (fifo_count == CW'(FIFO_DEPTH - 1) && !pop) ? BLOCKED : IDLE;
        else if (accept)
            state_nx = RECEIVE;
        else if (state == BLOCKED && pop)
            state_nx = IDLE;
    end

    always_ff @(posedge clock_100KHz)
        if (push)
            mem[wr_ptr] <= shift_nx;

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bits_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            data_out    <= '0;
            overrun_out <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state <= state_nx;
            ack_q <= ack_in;
            if (write_in && !status_out)
                overrun_out <= 1'b1;
            if (accept) begin
                shift_reg  <= shift_nx;
                bits_count <= last ? '0 : bits_count + BW'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push != pop)
                fifo_count <= push ? fifo_count + CW'(1) : fifo_count - CW'(1);
            // data_out is a registered copy of the head so it holds when the FIFO drains
            if (pop && fifo_count > CW'(1))
                data_out <= mem[rd_ptr + AW'(1)];
            else if (push && (fifo_count == '0 || pop))
                data_out <= shift_nx;
        end
    end
endmodule

// File: tb/tb_deserializador_fifo.sv
// tb_deserializador_fifo: directed checks of assembly, FIFO ordering, full/overrun,
// ack edge detection and asynchronous reset, for MSB-first and LSB-first builds.
module tb_deserializador_fifo;
    logic       clk = 1'b0, reset = 1'b0, data_in = 1'b0, write_in = 1'b0, ack_in = 1'b0;
    logic       status_out, data_ready, overrun_out;
    logic [7:0] data_out;
    logic [2:0] fifo_count;
    logic       l_status, l_ready, l_overrun;
    logic [7:0] l_data;
    logic [2:0] l_count;
    int         n_checks = 0, n_fail = 0;
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    deserializador_fifo u_msb (
        .clock_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
        .ack_in(ack_in), .status_out(status_out), .data_ready(data_ready),
        .data_out(data_out), .fifo_count(fifo_count), .overrun_out(overrun_out)
    );

    deserializador_fifo #(.MSB_FIRST(0)) u_lsb (
        .clock_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
        .ack_in(ack_in), .status_out(l_status), .data_ready(l_ready),
        .data_out(l_data), .fifo_count(l_count), .overrun_out(l_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_in  = b;
        write_in = 1'b1;
        tick();
        write_in = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--)
            send_bit(w[i]);
    endtask

    task automatic pulse_ack;
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        check("rst_count", fifo_count, 0);
        check("rst_ready", data_ready, 0);
        check("rst_status", status_out, 1);
        check("rst_data", data_out, 0);
        check("rst_overrun", overrun_out, 0);
        tick();
        reset = 1'b1;
        tick();

        send_word(8'hB2);
        check("t1_ready", data_ready, 1);
        check("t1_data", data_out, 8'hB2);
        check("t1_count", fifo_count, 1);
        check("t2_lsb_data", l_data, 8'h4D);
        check("t2_lsb_ready", l_ready, 1);
        pulse_ack();
        check("t1_pop_ready", data_ready, 0);
        check("t1_pop_count", fifo_count, 0);
        check("t1_hold_data", data_out, 8'hB2);

        send_bit(1); send_bit(0); send_bit(1);
        tick(); tick(); tick();
        check("t3_gap_bits", u_msb.bits_count, 3);
        check("t3_gap_ready", data_ready, 0);
        send_bit(1); send_bit(0); send_bit(0); send_bit(1); send_bit(0);
        check("t3_data", data_out, 8'hB2);
        check("t3_count", fifo_count, 1);
        pulse_ack();

        for (int k = 0; k < 4; k++)
            send_word(words[k]);
        check("t4_full_count", fifo_count, 4);
        check("t4_full_status", status_out, 0);
        check("t4_head", data_out, 8'h11);
        check("t4_no_overrun", overrun_out, 0);
        send_bit(1); send_bit(1); send_bit(1);
        check("t4_overrun", overrun_out, 1);
        check("t4_drop_count", fifo_count, 4);
        check("t4_drop_bits", u_msb.bits_count, 0);
        for (int k = 0; k < 4; k++) begin
            check("t4_order", data_out, words[k]);
            pulse_ack();
            if (k == 0)
                check("t4_status_freed", status_out, 1);
        end
        check("t4_empty_count", fifo_count, 0);
        check("t4_empty_ready", data_ready, 0);
        check("t4_hold_last", data_out, 8'h44);

        send_word(8'hA5);
        send_word(8'h3C);
        check("t5_count2", fifo_count, 2);
        ack_in = 1'b1;
        tick(); tick(); tick();
        ack_in = 1'b0;
        tick();
        check("t5_one_pop", fifo_count, 1);
        check("t5_head", data_out, 8'h3C);

        send_word(8'h5A);
        check("t6_count2", fifo_count, 2);
        send_bit(1); send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_count", fifo_count, 0);
        check("t6_ready", data_ready, 0);
        check("t6_overrun", overrun_out, 0);
        check("t6_status", status_out, 1);
        check("t6_data", data_out, 0);
        check("t6_bits", u_msb.bits_count, 0);
        tick();
        reset = 1'b1;
        tick();
        send_word(8'hC3);
        check("t6_fresh_data", data_out, 8'hC3);
        check("t6_fresh_count", fifo_count, 1);
        check("t6_fresh_lsb", l_data, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/deserializador_fifo.md
Name: deserializador_fifo

Overview:
- Parametrised successor to the team's serial-to-parallel deserializer.
- Shifts one bit per clock while write_in is high and assembles DATA_WIDTH-bit words, MSB- or LSB-first.
- Completed words go into an output FIFO of FIFO_DEPTH entries, so serial reception continues while the consumer is still acknowledging earlier words.
- Sits between the serial link front end and the parallel consumer in the 100 kHz domain.

Parameters:
- DATA_WIDTH, 8, bits per assembled word (>=2).
- FIFO_DEPTH, 4, number of completed words buffered (power of two, >=2).
- MSB_FIRST, 1: 1 = first received bit lands in data_out[DATA_WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
- clock_100KHz  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- data_in  in  1  serial data bit.
- write_in  in  1  data_in is valid this cycle.
- ack_in  in  1  consumer acknowledge; the rising edge pops one word.
- status_out  out  1  1 = block accepts serial bits (FIFO not full).
- data_ready  out  1  1 = data_out holds a valid word (FIFO not empty).
- data_out  out  DATA_WIDTH  head-of-FIFO word.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of words stored.
- overrun_out  out  1  sticky: a bit was presented while status_out=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - Shift register, bits_count, FIFO pointers, fifo_count, data_out, data_ready, overrun_out and the ack edge register all clear to 0.
  - status_out reads 1 (combinational: fifo_count < FIFO_DEPTH).
  - Reset mid-word discards the partial word and all stored words.
- Assembly FSM, states IDLE (bits_count=0), RECEIVE (0<bits_count<DATA_WIDTH) and BLOCKED (FIFO full):
  - A bit is accepted on a rising edge when write_in=1 and status_out=1.
  - MSB_FIRST=1: shift register shifts left, new bit enters at the LSB.
  - MSB_FIRST=0: shift register shifts right, new bit enters at the MSB.
  - bits_count increments on each accepted bit.
  - write_in=0 for any number of cycles holds the partial word and bits_count unchanged (gaps are legal).
  - On the accepted bit that makes bits_count reach DATA_WIDTH, the complete word (including that bit) is written into the FIFO on the same edge, bits_count returns to 0, and the FSM goes to IDLE, or to BLOCKED if fifo_count becomes FIFO_DEPTH.
  - BLOCKED leaves to IDLE on the cycle after a pop.
- Full condition:
  - status_out=0 whenever fifo_count=FIFO_DEPTH; no bits are accepted, partial or otherwise.
  - write_in=1 while status_out=0: bit dropped, shift state unchanged, overrun_out set to 1 on that edge.
  - overrun_out is cleared only by reset.
- Pop:
  - ack_in is registered once.
  - A pop occurs on the first clock where ack_in=1 and the previous sample was 0, and only if data_ready=1.
  - Holding ack_in high pops exactly one word; ack_in with an empty FIFO is ignored.
- Latency:
  - Word visible on data_out with data_ready=1 one cycle after the edge that accepted its last bit, when the FIFO was empty.
  - Otherwise it appears the cycle after the preceding word is popped.
- data_out is the FIFO head. When the FIFO is empty, data_out holds its last value; it is 0 after reset.
- Simultaneous push and pop (not full): fifo_count unchanged, both operations take effect.
- When full, a push cannot coincide with a pop, because status_out gates bit acceptance. The freed slot is usable from the next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH or underflows.

Test Plan:
1. Defaults; write_in=1 with bits 1,0,1,1,0,0,1,0 over 8 consecutive cycles -> the next cycle has data_ready=1, data_out=8'hB2, fifo_count=1; one ack_in pulse then gives data_ready=0, fifo_count=0.
2. MSB_FIRST=0; same bit sequence -> data_out=8'h4D.
3. Defaults; send bits 1,0,1, then write_in=0 for 3 cycles, then bits 1,0,0,1,0 -> data_out=8'hB2; bits_count holds at 3 during the gap.
4. Send 4 words 8'h11,8'h22,8'h33,8'h44 with no ack -> fifo_count=4, status_out=0; extra bits with write_in=1 are ignored and overrun_out=1; pop returns 8'h11,8'h22,8'h33,8'h44 in order; status_out=1 after the first pop.
5. Hold ack_in=1 for 3 cycles with 2 words stored -> exactly one pop, fifo_count 2->1.
6. Pull reset low after 5 bits of a word with 2 words stored -> fifo_count=0, data_ready=0, overrun_out=0, status_out=1; after release, a fresh 8-bit sequence yields the correct word with no residue.
